addr_req_fifo: RTL and testbench

- Downstream consumer of the registered address-request bundle {address, addressValid, valid}.
- Buffers accepted requests in a small FIFO and issues them to the memory-side port over a valid/ready handshake.
- Its ready output drives the upstream register's CE, so the register holds while the FIFO is full.
- Optionally discards requests whose addressValid is 0, and counts the discards.

---
 rtl/addr_req_fifo_if.sv | 30 +++
 rtl/addr_req_fifo.sv | 89 ++++++++
 tb/tb_addr_req_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/addr_req_fifo_if.sv
// Address-request link between the upstream register, the FIFO and the memory side.
// slave = FIFO side, master = the agent driving requests and consuming the head.
interface addr_req_fifo_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] I_address;
   logic                  I_addressValid;
   logic                  I_valid;
   logic                  I_ready;
   logic [ADDR_WIDTH-1:0] O_address;
   logic                  O_addressValid;
   logic                  O_valid;
   logic                  O_ready;
   logic [CW-1:0]         count;
   logic [CNT_WIDTH-1:0]  drop_count;

   modport slave (
      input  I_address, I_addressValid, I_valid, O_ready,
      output I_ready, O_address, O_addressValid, O_valid, count, drop_count
   );

   modport master (
      output I_address, I_addressValid, I_valid, O_ready,
      input  I_ready, O_address, O_addressValid, O_valid, count, drop_count
   );
endinterface

// File: rtl/addr_req_fifo.sv
// Request FIFO behind the upstream address register: 1-cycle latency, no bypass.
// I_ready (upstream CE) is decoded from occupancy only, so a full FIFO stalls the register.
module addr_req_fifo #(
   parameter int ADDR_WIDTH        = 8,
   parameter int DEPTH             = 4,
   parameter int DROP_INVALID_ADDR = 1,
   parameter int CNT_WIDTH         = 8
) (
   input logic            CLK,
   input logic            AsyncResetN,
   addr_req_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  addr_vld;
   } entry_t;

   entry_t               mem_q [DEPTH];
   entry_t               mem_d [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   logic i_ready, o_valid;
   logic in_fire, out_fire, drop, enq;

   assign i_ready = (count_q != CW'(DEPTH));
   assign o_valid = (count_q != '0);

   always_comb begin
      in_fire    = bus.I_valid & i_ready;
      out_fire   = o_valid & bus.O_ready;
      drop       = in_fire & (DROP_INVALID_ADDR != 0) & ~bus.I_addressValid;
      enq        = in_fire & ~drop;

      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;

      if (enq) begin
         mem_d[wr_ptr_q] = '{addr: bus.I_address, addr_vld: bus.I_addressValid};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (out_fire) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({enq, out_fire})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Saturate rather than wrap so a storm of bad requests stays visible.
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Storage is cleared too, so the head fields read 0 straight out of reset.
   always_ff @(posedge CLK or negedge AsyncResetN) begin
      if (!AsyncResetN) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.I_ready        = i_ready;
   assign bus.O_valid        = o_valid;
   assign bus.O_address      = mem_q[rd_ptr_q].addr;
   assign bus.O_addressValid = mem_q[rd_ptr_q].addr_vld;
   assign bus.count          = count_q;
   assign bus.drop_count     = drop_cnt_q;
endmodule

// File: tb/tb_addr_req_fifo.sv
// Directed bench: instance a drops invalid-address requests, instance b keeps them.
module tb_addr_req_fifo;
   logic CLK = 1'b0;
   logic AsyncResetN = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 CLK = ~CLK;

   addr_req_fifo_if #(.ADDR_WIDTH(8), .DEPTH(4), .CNT_WIDTH(8)) a_if ();
   addr_req_fifo_if #(.ADDR_WIDTH(8), .DEPTH(4), .CNT_WIDTH(8)) b_if ();

   addr_req_fifo #(.ADDR_WIDTH(8), .DEPTH(4), .DROP_INVALID_ADDR(1), .CNT_WIDTH(8)) dut_a (
      .CLK(CLK), .AsyncResetN(AsyncResetN), .bus(a_if.slave)
   );
   addr_req_fifo #(.ADDR_WIDTH(8), .DEPTH(4), .DROP_INVALID_ADDR(0), .CNT_WIDTH(8)) dut_b (
      .CLK(CLK), .AsyncResetN(AsyncResetN), .bus(b_if.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Upstream register model: the request is presented until an edge where I_ready was high.
   task automatic send_a(input logic [7:0] addr, input logic av);
      int n;
      a_if.I_address      = addr;
      a_if.I_addressValid = av;
      a_if.I_valid        = 1'b1;
      n = 0;
      while (!a_if.I_ready && n < 50) begin
         tick();
         n++;
      end
      check("send_a_ready_timeout", 32'(n < 50), 32'd1);
      tick();
      a_if.I_valid = 1'b0;
   endtask

   initial begin
      a_if.I_address = '0; a_if.I_addressValid = 1'b0; a_if.I_valid = 1'b0; a_if.O_ready = 1'b0;
      b_if.I_address = '0; b_if.I_addressValid = 1'b0; b_if.I_valid = 1'b0; b_if.O_ready = 1'b0;

      // Reset values
      #12;
      check("rst_count",      32'(a_if.count), 32'd0);
      check("rst_o_valid",    32'(a_if.O_valid), 32'd0);
      check("rst_o_address",  32'(a_if.O_address), 32'h00);
      check("rst_o_addr_vld", 32'(a_if.O_addressValid), 32'd0);
      check("rst_i_ready",    32'(a_if.I_ready), 32'd1);
      check("rst_drop_count", 32'(a_if.drop_count), 32'd0);
      AsyncResetN = 1'b1;
      tick();

      // Three enqueues, no dequeue
      send_a(8'h11, 1'b1);
      check("enq1_o_valid", 32'(a_if.O_valid), 32'd1);
      check("enq1_head",    32'(a_if.O_address), 32'h11);
      send_a(8'h22, 1'b1);
      send_a(8'h33, 1'b1);
      check("enq3_count",   32'(a_if.count), 32'd3);
      check("enq3_o_valid", 32'(a_if.O_valid), 32'd1);
      check("enq3_head",    32'(a_if.O_address), 32'h11);
      check("enq3_i_ready", 32'(a_if.I_ready), 32'd1);
      a_if.O_ready = 1'b1;
      check("drain_11", 32'(a_if.O_address), 32'h11); tick();
      check("drain_22", 32'(a_if.O_address), 32'h22); tick();
      check("drain_33", 32'(a_if.O_address), 32'h33); tick();
      a_if.O_ready = 1'b0;
      check("drain_count", 32'(a_if.count), 32'd0);
      check("drain_o_valid", 32'(a_if.O_valid), 32'd0);
      tick();
      check("empty_no_underflow", 32'(a_if.count), 32'd0);

      // Fill to full, hold a pending request, then release one slot
      for (int i = 0; i < 4; i++) send_a(8'hA0 + 8'(i), 1'b1);
      check("full_count",   32'(a_if.count), 32'd4);
      check("full_i_ready", 32'(a_if.I_ready), 32'd0);
      a_if.I_address = 8'hA4; a_if.I_addressValid = 1'b1; a_if.I_valid = 1'b1;
      tick(); tick(); tick();
      check("hold_count",   32'(a_if.count), 32'd4);
      check("hold_head",    32'(a_if.O_address), 32'hA0);
      check("hold_i_ready", 32'(a_if.I_ready), 32'd0);
      a_if.O_ready = 1'b1;
      tick();
      a_if.O_ready = 1'b0;
      check("pop_count",   32'(a_if.count), 32'd3);
      check("pop_i_ready", 32'(a_if.I_ready), 32'd1);
      check("pop_head",    32'(a_if.O_address), 32'hA1);
      tick();
      a_if.I_valid = 1'b0;
      check("a4_in_count", 32'(a_if.count), 32'd4);
      a_if.O_ready = 1'b1;
      check("wrap_a1", 32'(a_if.O_address), 32'hA1); tick();
      check("wrap_a2", 32'(a_if.O_address), 32'hA2); tick();
      check("wrap_a3", 32'(a_if.O_address), 32'hA3); tick();
      check("wrap_a4", 32'(a_if.O_address), 32'hA4); tick();
      check("wrap_empty", 32'(a_if.count), 32'd0);

      // Streaming with O_ready held high
      a_if.I_valid = 1'b1; a_if.I_addressValid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a_if.I_address = 8'(i);
         if (i == 0) check("stream_latency", 32'(a_if.O_valid), 32'd0);
         tick();
         check($sformatf("stream_head_%0d", i), 32'(a_if.O_address), 32'(i));
         check($sformatf("stream_count_%0d", i), 32'(a_if.count), 32'd1);
      end
      a_if.I_valid = 1'b0;
      tick();
      a_if.O_ready = 1'b0;
      check("stream_end_count", 32'(a_if.count), 32'd0);

      // Drop invalid-address requests and saturate the counter
      send_a(8'h05, 1'b0);
      send_a(8'h06, 1'b1);
      check("drop_count_1", 32'(a_if.count), 32'd1);
      check("drop_head",    32'(a_if.O_address), 32'h06);
      check("drop_head_av", 32'(a_if.O_addressValid), 32'd1);
      check("drop_cnt_1",   32'(a_if.drop_count), 32'd1);
      a_if.I_valid = 1'b1; a_if.I_addressValid = 1'b0; a_if.I_address = 8'h5A;
      for (int i = 0; i < 253; i++) tick();
      check("drop_cnt_254", 32'(a_if.drop_count), 32'd254);
      for (int i = 0; i < 47; i++) tick();
      check("drop_cnt_sat", 32'(a_if.drop_count), 32'd255);
      check("drop_no_enq",  32'(a_if.count), 32'd1);
      a_if.O_ready = 1'b1;
      tick();
      a_if.O_ready = 1'b0;
      a_if.I_valid = 1'b0;
      check("drop_and_pop_count", 32'(a_if.count), 32'd0);
      check("drop_and_pop_sat",   32'(a_if.drop_count), 32'd255);

      // Invalid address kept when dropping is disabled
      b_if.I_address = 8'h07; b_if.I_addressValid = 1'b0; b_if.I_valid = 1'b1;
      check("b_ready", 32'(b_if.I_ready), 32'd1);
      tick();
      b_if.I_valid = 1'b0;
      check("b_count",     32'(b_if.count), 32'd1);
      check("b_head",      32'(b_if.O_address), 32'h07);
      check("b_head_av",   32'(b_if.O_addressValid), 32'd0);
      check("b_drop_cnt",  32'(b_if.drop_count), 32'd0);

      // Asynchronous reset between edges
      send_a(8'h51, 1'b1);
      send_a(8'h52, 1'b1);
      send_a(8'h53, 1'b1);
      check("pre_rst_count", 32'(a_if.count), 32'd3);
      #2;
      AsyncResetN = 1'b0;
      #1;
      check("mid_rst_count",   32'(a_if.count), 32'd0);
      check("mid_rst_o_valid", 32'(a_if.O_valid), 32'd0);
      check("mid_rst_i_ready", 32'(a_if.I_ready), 32'd1);
      check("mid_rst_head",    32'(a_if.O_address), 32'h00);
      check("mid_rst_drop",    32'(a_if.drop_count), 32'd0);
      #1;
      AsyncResetN = 1'b1;
      send_a(8'h44, 1'b1);
      check("post_rst_head",  32'(a_if.O_address), 32'h44);
      check("post_rst_count", 32'(a_if.count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
